// File: rtl/layer_argmax.sv
// rtl/layer_argmax.sv - argmax over M signed neuron results per frame; LAYER_ARGMAX_SCORE_EN adds max_val
module layer_argmax #(
    parameter int DW = 8,
    parameter int M  = 10,
    parameter int IW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [DW-1:0] result,
    input  logic          ready,
    output logic          busy,
    output logic          done,
`ifdef LAYER_ARGMAX_SCORE_EN
    output logic [IW-1:0] class_idx,
    output logic [DW-1:0] max_val
`else
    output logic [IW-1:0] class_idx
`endif
);

    localparam logic [1:0] st_idle    = 2'd0;
    localparam logic [1:0] st_collect = 2'd1;
    localparam logic [1:0] st_done    = 2'd2;
    localparam logic [IW:0] last_cnt  = (IW+1)'(M - 1);

    logic [1:0]    state;
    logic          ready_d;
    logic [IW:0]   cnt;
    logic [DW-1:0] run_max;
    logic [IW-1:0] run_idx;

    logic          accept;
    logic          take;
    logic [DW-1:0] nxt_max;
    logic [IW-1:0] nxt_idx;

    // frame_start wins over a coincident ready edge, so the edge never counts
    assign accept = (state == st_collect) && ready && !ready_d && !frame_start;

    always_comb begin
        take    = (cnt == '0) || ($signed(result) > $signed(run_max));
        nxt_max = take ? result : run_max;
        nxt_idx = take ? cnt[IW-1:0] : run_idx;
    end

    assign busy = (state == st_collect);
    assign done = (state == st_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= st_idle;
            ready_d   <= 1'b0;
            cnt       <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            class_idx <= '0;
`ifdef LAYER_ARGMAX_SCORE_EN
            max_val   <= '0;
`endif
        end else begin
            ready_d <= ready;
            if (frame_start) begin
                state   <= st_collect;
                cnt     <= '0;
                run_max <= '0;
                run_idx <= '0;
            end else begin
                case (state)
                    st_collect: begin
                        if (accept) begin
                            run_max <= nxt_max;
                            run_idx <= nxt_idx;
                            cnt     <= cnt + 1'b1;
                            if (cnt == last_cnt) begin
                                state     <= st_done;
                                class_idx <= nxt_idx;
`ifdef LAYER_ARGMAX_SCORE_EN
                                max_val   <= nxt_max;
`endif
                            end
                        end
                    end
                    st_done: state <= st_idle;
                    default: state <= st_idle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_argmax.sv
// tb/tb_layer_argmax.sv - randomized self-checking bench for layer_argmax against an argmax reference
`timescale 1ns/1ps
module tb_layer_argmax;

    localparam int DW = 8;
    localparam int M  = 10;
    localparam int IW = $clog2(M);

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic [DW-1:0] result;
    logic          ready;
    logic          busy;
    logic          done;
    logic [IW-1:0] class_idx;
`ifdef LAYER_ARGMAX_SCORE_EN
    logic [DW-1:0] max_val;
`endif

    int vectors = 0;
    int errors  = 0;
    int done_pulses = 0;
    int vals[M];

    layer_argmax #(.DW(DW), .M(M)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .result(result),
        .ready(ready), .busy(busy), .done(done),
`ifdef LAYER_ARGMAX_SCORE_EN
        .max_val(max_val),
`endif
        .class_idx(class_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_idx();
        int best = 0;
        for (int k = 1; k < M; k++)
            if (vals[k] > vals[best]) best = k;
        return best;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // plays vals[] as one frame; chain starts the next frame in the DONE cycle
    task automatic play(input int hold, input bit chain);
        int e;
        e = ref_idx();
        for (int i = 0; i < M; i++) begin
            result = 8'(vals[i]);
            ready  = 1'b1;
            tick();
            if (i == M - 2) begin
                vectors++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL early_done: got %0b expected 0", done);
                end
            end
            if (i == M - 1) begin
                if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %0b expected 1", done); end
                vectors++;
                if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_done: got %0b expected 0", busy); end
                vectors++;
                if (class_idx !== IW'(e)) begin
                    errors++;
                    $display("FAIL class_idx: got %0d expected %0d", class_idx, e);
                end
                vectors++;
`ifdef LAYER_ARGMAX_SCORE_EN
                if (max_val !== 8'(vals[e])) begin
                    errors++;
                    $display("FAIL max_val: got %0d expected %0d", $signed(max_val), vals[e]);
                end
                vectors++;
`endif
            end
            repeat (hold - 1) tick();
            ready = 1'b0;
            if (i == M - 1 && chain) begin
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL chain_start: busy=%0b done=%0b expected busy=1 done=0", busy, done);
                end
                vectors++;
            end else begin
                tick();
            end
        end
        if (!chain) begin
            if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %0b expected 0", done); end
            vectors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0; ready = 1'b0; result = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_class_idx", 32'(class_idx), 0);
`ifdef LAYER_ARGMAX_SCORE_EN
        check("reset_max_val", 32'(max_val), 0);
`endif
    endtask

    task automatic test_spec_vector();
        int init[M] = '{3, -5, 7, 2, 7, 0, 1, -1, 6, 4};
        int p;
        vals = init;
        p = done_pulses;
        start_frame();
        check("collect_busy", 32'(busy), 1);
        play(1, 1'b0);
        check("spec_idx_const", 32'(class_idx), 2);
        check("spec_one_done", 32'(done_pulses - p), 1);
    endtask

    task automatic test_all_min();
        for (int i = 0; i < M; i++) vals[i] = -128;
        start_frame();
        play(1, 1'b0);
        check("all_min_idx", 32'(class_idx), 0);
    endtask

    task automatic test_held_ready();
        int p;
        for (int i = 0; i < M - 1; i++) vals[i] = int'($urandom_range(0, 254)) - 128;
        vals[M-1] = 127;
        p = done_pulses;
        start_frame();
        play(5, 1'b0);
        check("held_idx", 32'(class_idx), 9);
        check("held_one_done", 32'(done_pulses - p), 1);
    endtask

    task automatic test_restart();
        int p;
        p = done_pulses;
        start_frame();
        for (int i = 0; i < 4; i++) begin
            result = 8'(120 - i); ready = 1'b1; tick(); ready = 1'b0; tick();
        end
        start_frame();
        check("restart_busy", 32'(busy), 1);
        for (int i = 0; i < M; i++) vals[i] = int'($urandom_range(0, 200)) - 128;
        vals[5] = 90;
        play(1, 1'b0);
        check("restart_idx", 32'(class_idx), 5);
        check("restart_one_done", 32'(done_pulses - p), 1);
    endtask

    task automatic test_reset_mid();
        int p;
        start_frame();
        for (int i = 0; i < 6; i++) begin
            result = 8'(i); ready = 1'b1; tick(); ready = 1'b0; tick();
        end
        p = done_pulses;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < M; i++) begin
            result = 8'(50 + i); ready = 1'b1; tick(); ready = 1'b0; tick();
        end
        check("rstmid_no_done", 32'(done_pulses - p), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_idx", 32'(class_idx), 0);
    endtask

    task automatic test_fs_collision();
        int p;
        start_frame();
        for (int i = 0; i < 2; i++) begin
            result = 8'(i); ready = 1'b1; tick(); ready = 1'b0; tick();
        end
        p = done_pulses;
        frame_start = 1'b1; result = 8'(100); ready = 1'b1;
        tick();
        frame_start = 1'b0; ready = 1'b0;
        tick();
        for (int i = 0; i < M; i++) vals[i] = int'($urandom_range(0, 227)) - 128;
        play(1, 1'b0);
        check("collision_one_done", 32'(done_pulses - p), 1);
    endtask

    task automatic test_back_to_back();
        start_frame();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < M; i++) vals[i] = int'($urandom_range(0, 255)) - 128;
            if (f % 2 == 0) vals[$urandom_range(0, M-1)] = vals[$urandom_range(0, M-1)];
            play((f == 5) ? int'($urandom_range(1, 3)) : 1, f != 5);
        end
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_all_min();
        test_held_ready();
        test_restart();
        test_reset_mid();
        test_fs_collision();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
